// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshaking with the shared memory ports. Illegal opcodes and memory timeouts park it in FAULT.
module multi_cycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        IMemReady,
    input  logic        DMemReady,
    output logic        IMemReq,
    output logic        DMemReq,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Uncondbranch,
    output logic [1:0]  ALUOp,
    output logic        Fault,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_ILL, OP_LDUR, OP_STUR, OP_RTYPE, OP_IMM, OP_CBZ, OP_B
    } opclass_t;

    typedef struct packed {
        logic       imemreq;
        logic       dmemreq;
        logic       irwrite;
        logic       pcwrite;
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       uncondbranch;
        logic [1:0] aluop;
        logic       fault;
    } ctrl_t;

    function automatic opclass_t classify(input logic [10:0] op);
        casez (op)
            11'b11111000010: return OP_LDUR;
            11'b11111000000: return OP_STUR;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: return OP_RTYPE;
            11'b1011001000?,
            11'b11010011011: return OP_IMM;
            11'b10110100???: return OP_CBZ;
            11'b000101?????: return OP_B;
            default:         return OP_ILL;
        endcase
    endfunction

    state_t           state, nxt;
    logic [10:0]      op_reg;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             at_limit;
    opclass_t         cls, dcls;
    ctrl_t            c, co;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= S_FETCH;
            op_reg <= '0;
            cnt    <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == S_DECODE)
                op_reg <= Opcode;
        end
    end

    // Saturating wait counter; cleared on every state change.
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign at_limit = (cnt >= CNT_W'(TIMEOUT - 1));
    assign cls      = classify(op_reg);
    assign dcls     = classify(Opcode);

    always_comb begin
        nxt     = state;
        cnt_nxt = '0;
        c       = '0;
        case (state)
            S_FETCH: begin
                c.imemreq = 1'b1;
                if (IMemReady) begin
                    c.irwrite = 1'b1;
                    nxt       = S_DECODE;
                end else if (at_limit) begin
                    nxt = S_FAULT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_DECODE: nxt = (dcls == OP_ILL) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    OP_LDUR: begin c.alusrc = 1'b1; nxt = S_MEM; end
                    OP_STUR: begin c.alusrc = 1'b1; c.reg2loc = 1'b1; nxt = S_MEM; end
                    OP_RTYPE: begin c.aluop = 2'b10; nxt = S_WB; end
                    OP_IMM: begin c.alusrc = 1'b1; c.aluop = 2'b10; nxt = S_WB; end
                    OP_CBZ: begin
                        c.reg2loc = 1'b1;
                        c.branch  = 1'b1;
                        c.aluop   = 2'b01;
                        c.pcwrite = 1'b1;
                        nxt       = S_FETCH;
                    end
                    OP_B: begin
                        c.branch       = 1'b1;
                        c.uncondbranch = 1'b1;
                        c.pcwrite      = 1'b1;
                        nxt            = S_FETCH;
                    end
                    default: nxt = S_FAULT;
                endcase
            end
            S_MEM: begin
                c.dmemreq  = 1'b1;
                c.alusrc   = 1'b1;
                c.memread  = (cls == OP_LDUR);
                c.memwrite = (cls == OP_STUR);
                c.reg2loc  = (cls == OP_STUR);
                if (cls != OP_LDUR && cls != OP_STUR) begin
                    nxt = S_FAULT;
                end else if (DMemReady) begin
                    // A store retires here; a load still needs its register write.
                    c.pcwrite = (cls == OP_STUR);
                    nxt       = (cls == OP_STUR) ? S_FETCH : S_WB;
                end else if (at_limit) begin
                    nxt = S_FAULT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WB: begin
                c.regwrite = 1'b1;
                c.pcwrite  = 1'b1;
                c.memtoreg = (cls == OP_LDUR);
                nxt        = S_FETCH;
            end
            S_FAULT: c.fault = 1'b1;
            default: nxt = S_FAULT;
        endcase
    end

    // Reset masks every output, including the combinational FETCH request.
    assign co    = Reset ? '0 : c;
    assign State = Reset ? 3'd0 : state;

    assign IMemReq      = co.imemreq;
    assign DMemReq      = co.dmemreq;
    assign IRWrite      = co.irwrite;
    assign PCWrite      = co.pcwrite;
    assign Reg2Loc      = co.reg2loc;
    assign ALUSrc       = co.alusrc;
    assign MemToReg     = co.memtoreg;
    assign RegWrite     = co.regwrite;
    assign MemRead      = co.memread;
    assign MemWrite     = co.memwrite;
    assign Branch       = co.branch;
    assign Uncondbranch = co.uncondbranch;
    assign ALUOp        = co.aluop;
    assign Fault        = co.fault;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized instruction stream against a per-instruction phase model of the sequencer,
// plus directed latency, fault, timeout and asynchronous-reset scenarios.
module tb_multi_cycle_control;

    localparam int TO = 15;

    // Instruction kinds used by the model.
    localparam int K_LDUR = 0, K_STUR = 1, K_ADD = 2, K_SUB = 3, K_AND = 4,
                   K_ORR = 5, K_CBZ = 6, K_B = 7, K_ORRI = 8, K_LSL = 9;

    typedef struct packed {
        logic [2:0] st;
        logic imr, dmr, irw, pcw, r2l, als, m2r, rgw, mrd, mwr, br, ub;
        logic [1:0] aop;
        logic flt;
    } obs_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] Opcode = '0;
    logic        IMemReady = 1'b0, DMemReady = 1'b0;
    logic        IMemReq, DMemReq, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite;
    logic        MemRead, MemWrite, Branch, Uncondbranch, Fault;
    logic [1:0]  ALUOp;
    logic [2:0]  State;
    obs_t        obs;

    int checks = 0;
    int errors = 0;

    multi_cycle_control #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode),
        .IMemReady(IMemReady), .DMemReady(DMemReady),
        .IMemReq(IMemReq), .DMemReq(DMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Uncondbranch(Uncondbranch),
        .ALUOp(ALUOp), .Fault(Fault), .State(State)
    );

    always #5 CLK = ~CLK;

    assign obs = {State, IMemReq, DMemReq, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg,
                  RegWrite, MemRead, MemWrite, Branch, Uncondbranch, ALUOp, Fault};

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(1, 0));
    endfunction

    function automatic logic [10:0] ro();
        return 11'($urandom);
    endfunction

    function automatic logic [10:0] gen_op(input int k);
        logic [10:0] r;
        r = ro();
        case (k)
            K_LDUR: return 11'b11111000010;
            K_STUR: return 11'b11111000000;
            K_ADD:  return 11'b10001011000;
            K_SUB:  return 11'b11001011000;
            K_AND:  return 11'b10001010000;
            K_ORR:  return 11'b10101010000;
            K_CBZ:  return {8'b10110100, r[2:0]};
            K_B:    return {6'b000101, r[4:0]};
            K_ORRI: return {10'b1011001000, r[0]};
            default: return 11'b11010011011;
        endcase
    endfunction

    // Expected observable values for each phase of an instruction.
    function automatic obs_t o_fetch(input logic rdy);
        obs_t o = '0;
        o.st = 3'd0; o.imr = 1'b1; o.irw = rdy;
        return o;
    endfunction

    function automatic obs_t o_decode();
        obs_t o = '0;
        o.st = 3'd1;
        return o;
    endfunction

    function automatic obs_t o_exec(input int k);
        obs_t o = '0;
        o.st = 3'd2;
        if (k == K_LDUR || k == K_STUR) o.als = 1'b1;
        if (k == K_STUR) o.r2l = 1'b1;
        if (k >= K_ADD && k <= K_ORR) o.aop = 2'b10;
        if (k == K_ORRI || k == K_LSL) begin o.als = 1'b1; o.aop = 2'b10; end
        if (k == K_CBZ) begin o.r2l = 1'b1; o.br = 1'b1; o.aop = 2'b01; o.pcw = 1'b1; end
        if (k == K_B) begin o.br = 1'b1; o.ub = 1'b1; o.pcw = 1'b1; end
        return o;
    endfunction

    function automatic obs_t o_mem(input int k, input logic rdy);
        obs_t o = '0;
        o.st = 3'd3; o.dmr = 1'b1; o.als = 1'b1;
        o.mrd = (k == K_LDUR);
        o.mwr = (k == K_STUR);
        o.r2l = (k == K_STUR);
        o.pcw = (k == K_STUR) && rdy;
        return o;
    endfunction

    function automatic obs_t o_wb(input int k);
        obs_t o = '0;
        o.st = 3'd4; o.rgw = 1'b1; o.pcw = 1'b1; o.m2r = (k == K_LDUR);
        return o;
    endfunction

    function automatic obs_t o_fault();
        obs_t o = '0;
        o.st = 3'd7; o.flt = 1'b1;
        return o;
    endfunction

    // One clock: release reset, apply inputs after the falling edge, then check.
    task automatic cyc(input string tag, input logic ir, input logic dr,
                       input logic [10:0] op, input obs_t e);
        @(negedge CLK);
        Reset = 1'b0; IMemReady = ir; DMemReady = dr; Opcode = op;
        #1;
        chk(tag, obs, e);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1; IMemReady = rb(); DMemReady = rb(); Opcode = ro();
        #1 chk("rst_hold", obs, '0);
        @(negedge CLK);
        #1 chk("rst_hold2", obs, '0);
    endtask

    // Whole instruction: fw fetch stalls, mw memory stalls. Opcode is garbage outside DECODE.
    task automatic run_op(input int k, input logic [10:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) cyc("fetch_wait", 1'b0, rb(), ro(), o_fetch(1'b0));
        cyc("fetch", 1'b1, rb(), ro(), o_fetch(1'b1));
        cyc("decode", rb(), rb(), op, o_decode());
        cyc("exec", rb(), rb(), ro(), o_exec(k));
        if (k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i < mw; i++) cyc("mem_wait", rb(), 1'b0, ro(), o_mem(k, 1'b0));
            cyc("mem", rb(), 1'b1, ro(), o_mem(k, 1'b1));
        end
        if (k != K_CBZ && k != K_B && k != K_STUR)
            cyc("wb", rb(), rb(), ro(), o_wb(k));
    endtask

    initial begin
        logic [10:0] ill [4];
        int k;
        ill[0] = 11'b00000000000;
        ill[1] = 11'b11111111111;
        ill[2] = 11'b11111000001;
        ill[3] = 11'b10001011001;

        do_reset();

        // ADD, LDUR with three memory stalls, CBZ then STUR back to back
        run_op(K_ADD, gen_op(K_ADD), 0, 0);
        run_op(K_LDUR, gen_op(K_LDUR), 0, 3);
        run_op(K_CBZ, 11'b10110100101, 0, 0);
        run_op(K_STUR, gen_op(K_STUR), 0, 0);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(9, 0));
            run_op(k, gen_op(k), int'($urandom_range(5, 0)), int'($urandom_range(5, 0)));
        end

        // Reset asserted asynchronously in the middle of a STUR memory stall
        cyc("fetch", 1'b1, rb(), ro(), o_fetch(1'b1));
        cyc("decode", rb(), rb(), gen_op(K_STUR), o_decode());
        cyc("exec", rb(), rb(), ro(), o_exec(K_STUR));
        cyc("mem_wait", rb(), 1'b0, ro(), o_mem(K_STUR, 1'b0));
        #1 Reset = 1'b1;
        #1 chk("async_rst", obs, '0);
        @(negedge CLK);
        #1 chk("async_rst_hold", obs, '0);
        run_op(K_ADD, gen_op(K_ADD), 0, 0);

        // Illegal opcode: sticky fault regardless of inputs, cleared only by reset
        cyc("fetch", 1'b1, rb(), ro(), o_fetch(1'b1));
        cyc("decode_ill", rb(), rb(), ill[$urandom_range(3, 0)], o_decode());
        for (int i = 0; i < 20; i++) cyc("fault", rb(), rb(), ro(), o_fault());
        do_reset();
        run_op(K_B, gen_op(K_B), 1, 0);

        // Fetch timeout: FAULT exactly TO cycles after FETCH entry
        for (int i = 0; i < TO; i++) cyc("tmo_fetch", 1'b0, rb(), ro(), o_fetch(1'b0));
        for (int i = 0; i < 3; i++) cyc("tmo_fault", rb(), rb(), ro(), o_fault());
        do_reset();

        // Memory timeout on a load
        cyc("fetch", 1'b1, rb(), ro(), o_fetch(1'b1));
        cyc("decode", rb(), rb(), gen_op(K_LDUR), o_decode());
        cyc("exec", rb(), rb(), ro(), o_exec(K_LDUR));
        for (int i = 0; i < TO; i++) cyc("tmo_mem", rb(), 1'b0, ro(), o_mem(K_LDUR, 1'b0));
        cyc("tmo_mem_fault", rb(), rb(), ro(), o_fault());
        do_reset();
        run_op(K_ORRI, gen_op(K_ORRI), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
